// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : register map, STATUS layout and FSM states for uart_tx_dev
// Rev 1.0
// ============================================================================
package uart_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_DIV    = 2'd2;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_IE        = 4;
   localparam int ST_COUNT_LSB = 8;

   localparam logic [15:0] DEFAULT_DIV_C = 16'd434;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   // A divisor of zero runs at the fastest rate, identical to one.
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// uart_fifo : show-ahead synchronous byte FIFO, wrap-bit pointers
// Rev 1.0
// ============================================================================
module uart_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == PW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is still taken when a pop frees a slot that cycle.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_dev.sv
`default_nettype none
// ============================================================================
// uart_tx_dev : memory-mapped 8N1 UART transmitter with FIFO and drain irq
// Rev 1.0
// ============================================================================
module uart_tx_dev
   import uart_pkg::*;
#(
   parameter int          DEPTH       = 8,
   parameter logic [15:0] DEFAULT_DIV = DEFAULT_DIV_C
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq,
   output logic        txd
);

   localparam int PW = $clog2(DEPTH) + 1;

   logic          fifo_push;
   logic          fifo_pop;
   logic          full;
   logic          empty;
   logic [7:0]    fifo_rdata;
   logic [PW-1:0] fifo_count;
   logic [4:0]    count_ext;

   logic [15:0]   div_reg;
   logic          ie;
   logic          ovf;
   logic          busy;

   tx_state_t     state, state_next;
   logic [15:0]   timer, timer_next;
   logic [15:0]   div_lat, div_lat_next;
   logic [2:0]    idx, idx_next;
   logic [7:0]    shift, shift_next;
   logic          txd_next;
   logic [15:0]   div_eff;
   logic          bit_done;

   logic          wr_data, wr_status, wr_div;
   logic          unused_ok;

   uart_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (din[7:0]),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign wr_data   = we & (addr == ADDR_DATA);
   assign wr_status = we & (addr == ADDR_STATUS);
   assign wr_div    = we & (addr == ADDR_DIV);
   assign fifo_push = wr_data;
   assign count_ext = 5'(fifo_count);
   assign unused_ok = ^{din[31:16], din[7:5], din[2:0], count_ext[4]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_reg <= DEFAULT_DIV;
         ie      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (wr_div)    div_reg <= din[15:0];
         if (wr_status) ie      <= din[ST_IE];
         // Overflow set has priority over a software clear.
         if (wr_data && full && !fifo_pop)      ovf <= 1'b1;
         else if (wr_status && din[ST_OVF])     ovf <= 1'b0;
      end
   end

   assign busy = (state != S_IDLE);
   assign irq  = ie & empty & ~busy;

   always_comb begin
      dout = 32'd0;
      case (addr)
         ADDR_STATUS: dout = {20'd0, count_ext[3:0], 3'd0, ie, ovf, empty, full, busy};
         ADDR_DIV:    dout = {16'd0, div_reg};
         default:     dout = 32'd0;
      endcase
   end

   assign div_eff  = eff_div(div_reg);
   assign bit_done = (timer == 16'd0);

   always_comb begin
      state_next   = state;
      timer_next   = timer;
      div_lat_next = div_lat;
      idx_next     = idx;
      shift_next   = shift;
      txd_next     = txd;
      fifo_pop     = 1'b0;
      case (state)
         S_IDLE: begin
            txd_next = 1'b1;
            if (!empty) begin
               fifo_pop     = 1'b1;
               shift_next   = fifo_rdata;
               div_lat_next = div_eff;
               timer_next   = div_eff - 16'd1;
               txd_next     = 1'b0;
               state_next   = S_START;
            end
         end
         S_START: begin
            if (bit_done) begin
               timer_next = div_lat - 16'd1;
               idx_next   = 3'd0;
               txd_next   = shift[0];
               state_next = S_DATA;
            end else begin
               timer_next = timer - 16'd1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               timer_next = div_lat - 16'd1;
               if (idx == 3'd7) begin
                  txd_next   = 1'b1;
                  state_next = S_STOP;
               end else begin
                  idx_next = idx + 3'd1;
                  txd_next = shift[idx + 3'd1];
               end
            end else begin
               timer_next = timer - 16'd1;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               // Chain straight into the next start bit when more data waits.
               if (!empty) begin
                  fifo_pop     = 1'b1;
                  shift_next   = fifo_rdata;
                  div_lat_next = div_eff;
                  timer_next   = div_eff - 16'd1;
                  txd_next     = 1'b0;
                  state_next   = S_START;
               end else begin
                  txd_next   = 1'b1;
                  state_next = S_IDLE;
               end
            end else begin
               timer_next = timer - 16'd1;
            end
         end
         default: begin
            txd_next   = 1'b1;
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         timer   <= 16'd0;
         div_lat <= 16'd1;
         idx     <= 3'd0;
         shift   <= 8'd0;
         txd     <= 1'b1;
      end else begin
         state   <= state_next;
         timer   <= timer_next;
         div_lat <= div_lat_next;
         idx     <= idx_next;
         shift   <= shift_next;
         txd     <= txd_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_dev.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_dev : scoreboard bench with a frame-timing reference model
// Rev 1.0
// ============================================================================
module tb_uart_tx_dev;
   import uart_pkg::*;

   localparam int DEPTH = 8;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        we    = 1'b0;
   logic [1:0]  addr  = ADDR_STATUS;
   logic [31:0] din   = 32'd0;
   logic [31:0] dout;
   logic        irq;
   logic        txd;

   int checks = 0;
   int errors = 0;

   uart_tx_dev #(.DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .addr  (addr),
      .din   (din),
      .dout  (dout),
      .irq   (irq),
      .txd   (txd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      int         d;
   } frame_t;

   // Reference model: bytes waiting, frames owed to the line, frame timing.
   logic [7:0]  mq[$];
   frame_t      sb[$];
   logic        m_busy = 1'b0;
   logic        m_ie   = 1'b0;
   logic        m_ovf  = 1'b0;
   int          m_left = 0;
   logic [15:0] m_div  = 16'd434;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_dout(input logic [1:0] a);
      logic [3:0] n;
      n = 4'(mq.size());
      case (a)
         ADDR_STATUS: return {20'd0, n, 3'd0, m_ie, m_ovf, mq.size() == 0, mq.size() == DEPTH, m_busy};
         ADDR_DIV:    return {16'd0, m_div};
         default:     return 32'd0;
      endcase
   endfunction

   initial begin : model
      logic   do_pop;
      frame_t f;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            mq.delete();
            sb.delete();
            m_busy = 1'b0;
            m_left = 0;
            m_ie   = 1'b0;
            m_ovf  = 1'b0;
            m_div  = 16'd434;
         end else begin
            do_pop = 1'b0;
            if (m_busy) begin
               m_left--;
               if (m_left == 0) begin
                  if (mq.size() > 0) do_pop = 1'b1;
                  else               m_busy = 1'b0;
               end
            end else if (mq.size() > 0) begin
               do_pop = 1'b1;
            end
            if (do_pop) begin
               f.b    = mq.pop_front();
               f.d    = (m_div == 16'd0) ? 1 : int'(m_div);
               sb.push_back(f);
               m_busy = 1'b1;
               m_left = 10 * f.d;
            end
            if (we) begin
               case (addr)
                  ADDR_DATA: begin
                     if (mq.size() < DEPTH) mq.push_back(din[7:0]);
                     else                   m_ovf = 1'b1;
                  end
                  ADDR_STATUS: begin
                     m_ie = din[4];
                     if (din[3]) m_ovf = 1'b0;
                  end
                  ADDR_DIV: m_div = din[15:0];
                  default: ;
               endcase
            end
         end
      end
   end

   initial begin : reg_checker
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            check("dout", dout, exp_dout(addr));
            check("irq", {31'd0, irq}, {31'd0, m_ie & (mq.size() == 0) & ~m_busy});
         end
      end
   end

   initial begin : line_monitor
      frame_t     f;
      logic       bad, aborted, expb;
      logic [7:0] obs;
      int         waitc;
      forever begin
         @(negedge clk);
         if (!reset && txd === 1'b0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame txd=0 while line should idle at %0t", $time);
               waitc = 0;
               while (txd !== 1'b1 && waitc < 1000) begin
                  @(negedge clk);
                  waitc++;
               end
            end else begin
               f       = sb.pop_front();
               bad     = 1'b0;
               aborted = 1'b0;
               obs     = 8'd0;
               for (int k = 0; k < 10 && !aborted; k++) begin
                  for (int c = 0; c < f.d && !aborted; c++) begin
                     if (k != 0 || c != 0) @(negedge clk);
                     if (reset) begin
                        aborted = 1'b1;
                     end else begin
                        expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : f.b[k-1];
                        if (txd !== expb) bad = 1'b1;
                        if (k >= 1 && k <= 8 && c == 0) obs[k-1] = txd;
                     end
                  end
               end
               if (!aborted) begin
                  checks++;
                  if (bad) begin
                     errors++;
                     $display("FAIL frame actual=%02h expected=%02h div=%0d (bit value or bit width wrong)",
                              obs, f.b, f.d);
                  end
               end
            end
         end
      end
   end

   task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d);
      we   = w;
      addr = a;
      din  = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, ADDR_STATUS, 32'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((m_busy || mq.size() != 0 || sb.size() != 0) && n < 3000) begin
         idle(1);
         n++;
      end
      idle(3);
      check("drain", {31'd0, (n < 3000)}, 32'd1);
   endtask

   initial begin : stimulus
      int r;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset values: STATUS then DIV.
      idle(3);
      cyc(1'b0, ADDR_DIV, 32'd0);
      check("idle_txd", {31'd0, txd}, 32'd1);

      // Single 0xA5 frame at DIV=4.
      cyc(1'b1, ADDR_DIV, 32'd4);
      cyc(1'b1, ADDR_DATA, 32'h0000_00A5);
      idle(50);

      // Fill past capacity, then clear the overflow flag.
      for (int i = 0; i < 10; i++) cyc(1'b1, ADDR_DATA, 32'($urandom_range(0, 255)));
      idle(2);
      cyc(1'b1, ADDR_STATUS, 32'h8);
      drain();

      // Drain interrupt.
      cyc(1'b1, ADDR_STATUS, 32'h10);
      idle(3);
      cyc(1'b1, ADDR_DATA, 32'h0000_003C);
      idle(48);

      // Asynchronous reset in the middle of a data bit.
      cyc(1'b1, ADDR_DATA, 32'h0000_00F0);
      idle(8);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_status", dout, 32'h0000_0004);
      @(negedge clk);
      idle(2);
      reset = 1'b0;
      idle(20);
      check("post_rst_txd", {31'd0, txd}, 32'd1);

      // DIV=0 behaves as DIV=1.
      cyc(1'b1, ADDR_DIV, 32'd0);
      cyc(1'b1, ADDR_DATA, 32'h0000_0096);
      idle(15);

      // Randomised traffic.
      cyc(1'b1, ADDR_STATUS, 32'h10);
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if (r < 25)      cyc(1'b1, ADDR_DATA, $urandom);
         else if (r < 28) cyc(1'b1, ADDR_DIV, $urandom & 32'hFFFF_0003);
         else if (r < 33) cyc(1'b1, ADDR_STATUS, $urandom);
         else if (r < 35) cyc(1'b1, 2'd3, $urandom);
         else             cyc(1'b0, 2'($urandom_range(0, 3)), $urandom);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

endmodule
`default_nettype wire
